sprite_engine: RTL and testbench

SPRITE_ENGINE -- requirements
Module: sprite_engine

---
 rtl/sprite_engine.sv | 112 +++++++++++
 tb/tb_sprite_engine.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_engine.sv
// Sprite renderer: maps the current raster position to a sprite ROM address,
// registers the palette index three pixel clocks later, and steps the animation frame.
module sprite_engine #(
  parameter int SPR_W           = 30,
  parameter int SPR_H           = 30,
  parameter int NUM_FRAMES      = 4,
  parameter int FRAME_DIV       = 8,
  parameter int IDX_W           = 3,
  parameter int TRANSPARENT_IDX = 0,
  parameter int LOOP            = 1,
  localparam int ADDR_W  = $clog2(SPR_W * SPR_H * NUM_FRAMES),
  localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               Reset,
  input  logic               frame_start,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic [9:0]         SpriteX,
  input  logic [9:0]         SpriteY,
  input  logic               blank,
  input  logic               enable,
  input  logic               mirror,
  input  logic               anim_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [IDX_W-1:0]   rom_data,
  output logic [IDX_W-1:0]   pal_index,
  output logic               pix_valid,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               anim_done
);

  localparam int FRAME_SIZE = SPR_W * SPR_H;
  localparam int DIV_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic signed [10:0] ox;
  logic signed [10:0] oy;
  logic signed [11:0] lx;
  logic signed [11:0] ly;
  logic signed [11:0] cx;
  logic               hit;
  logic [ADDR_W-1:0]  addr_next;
  logic [2:0]         ctl_s0;
  logic [2:0]         ctl_d [1:2];
  logic [DIV_W-1:0]   div_cnt_reg;
  logic [FRAME_W-1:0] last_frame;

  // Local coordinates are one bit wider than the origin so a far-right DrawX
  // against a negative origin cannot overflow and wrap back into the box.
  assign ox = $signed({1'b0, SpriteX}) - 11'(SPR_W / 2);
  assign oy = $signed({1'b0, SpriteY}) - 11'(SPR_H / 2);
  assign lx = $signed({2'b00, DrawX}) - $signed({ox[10], ox});
  assign ly = $signed({2'b00, DrawY}) - $signed({oy[10], oy});

  assign hit = !lx[11] && (lx < 12'(SPR_W)) && !ly[11] && (ly < 12'(SPR_H));
  assign cx  = mirror ? (12'(SPR_W - 1) - lx) : lx;

  assign addr_next = ADDR_W'(frame_idx) * ADDR_W'(FRAME_SIZE)
                   + ADDR_W'(ly) * ADDR_W'(SPR_W)
                   + ADDR_W'(cx);

  assign ctl_s0     = {hit, blank, enable};
  assign last_frame = FRAME_W'(NUM_FRAMES - 1);

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      rom_addr  <= '0;
      pal_index <= '0;
      pix_valid <= 1'b0;
      ctl_d[1]  <= '0;
      ctl_d[2]  <= '0;
    end else begin
      if (hit) begin
        rom_addr <= addr_next;
      end
      ctl_d[1]  <= ctl_s0;
      ctl_d[2]  <= ctl_d[1];
      pal_index <= rom_data;
      pix_valid <= ctl_d[2][2] & ctl_d[2][1] & ctl_d[2][0]
                 & (rom_data != IDX_W'(TRANSPARENT_IDX));
    end
  end

  // Animation: frame_idx only moves on a qualified frame_start, so pixels
  // already past the address stage keep the frame they were fetched with.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      div_cnt_reg <= '0;
      frame_idx   <= '0;
      anim_done   <= 1'b0;
    end else if (frame_start && anim_en) begin
      if (div_cnt_reg == DIV_W'(FRAME_DIV - 1)) begin
        div_cnt_reg <= '0;
        if (frame_idx == last_frame) begin
          if (LOOP != 0) begin
            frame_idx <= '0;
          end else begin
            anim_done <= 1'b1;
          end
        end else begin
          frame_idx <= frame_idx + FRAME_W'(1);
          if ((LOOP == 0) && (frame_idx == last_frame - FRAME_W'(1))) begin
            anim_done <= 1'b1;
          end
        end
      end else begin
        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sprite_engine.sv
// Bench for sprite_engine: directed vector table, animation/reset sequences and
// randomized raster traffic checked against a per-pixel reference model.
module tb_sprite_engine;

  localparam int W = 30;
  localparam int H = 30;

  logic        vga_clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, SpriteX = '0, SpriteY = '0;
  logic        blank = 1'b0, enable = 1'b0, mirror = 1'b0, anim_en = 1'b0;
  logic [11:0] rom_addr, rom_addr_h;
  logic [2:0]  rom_data;
  logic [2:0]  pal_index, pal_index_h;
  logic        pix_valid, pix_valid_h;
  logic [1:0]  frame_idx, frame_idx_h;
  logic        anim_done, anim_done_h;

  logic [2:0]  rom_mem [0:4095];

  always #5 vga_clk = ~vga_clk;

  always_ff @(posedge vga_clk) rom_data <= rom_mem[rom_addr];

  sprite_engine #(.LOOP(1)) dut (
    .vga_clk(vga_clk), .Reset(Reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .SpriteX(SpriteX), .SpriteY(SpriteY),
    .blank(blank), .enable(enable), .mirror(mirror), .anim_en(anim_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .pal_index(pal_index),
    .pix_valid(pix_valid), .frame_idx(frame_idx), .anim_done(anim_done)
  );

  sprite_engine #(.LOOP(0)) dut_hold (
    .vga_clk(vga_clk), .Reset(Reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .SpriteX(SpriteX), .SpriteY(SpriteY),
    .blank(blank), .enable(enable), .mirror(mirror), .anim_en(anim_en),
    .rom_addr(rom_addr_h), .rom_data(rom_data), .pal_index(pal_index_h),
    .pix_valid(pix_valid_h), .frame_idx(frame_idx_h), .anim_done(anim_done_h)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: qualified frame_start pulses since reset, the
  // current ROM address, and a queue of pixel results still in flight.
  typedef struct { bit valid; int pal; bit chk; } pix_t;
  pix_t q[$];
  int   pulses = 0;
  int   m_addr = 0;

  typedef struct {
    int dx, dy, sx, sy;
    bit mir, blk, en;
    int addr;
    bit valid;
    int pal;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int frame_of(input int p, input bit loop);
    int s = p / 8;
    return loop ? (s % 4) : ((s > 3) ? 3 : s);
  endfunction

  task automatic tick();
    pix_t cur, ne;
    int ox, oy, lx, ly, cx;
    bit hit;
    if (Reset) begin
      pulses = 0;
      m_addr = 0;
      q.delete();
      cur = '{valid: 1'b0, pal: 0, chk: 1'b1};
      ne  = '{valid: 1'b0, pal: 0, chk: 1'b0};
      q.push_back(ne);
      q.push_back(ne);
    end else begin
      ox  = int'(SpriteX) - W / 2;
      oy  = int'(SpriteY) - H / 2;
      lx  = int'(DrawX) - ox;
      ly  = int'(DrawY) - oy;
      hit = (lx >= 0) && (lx < W) && (ly >= 0) && (ly < H);
      cx  = mirror ? (W - 1 - lx) : lx;
      if (hit) m_addr = frame_of(pulses, 1'b1) * W * H + ly * W + cx;
      ne.pal   = int'(rom_mem[m_addr]);
      ne.valid = hit && blank && enable && (ne.pal != 0);
      ne.chk   = 1'b1;
      cur = q.pop_front();
      q.push_back(ne);
      if (frame_start && anim_en) pulses++;
    end
    @(posedge vga_clk);
    #1;
    chk("rom_addr", int'(rom_addr), m_addr);
    chk("pix_valid", int'(pix_valid), int'(cur.valid));
    if (cur.chk) chk("pal_index", int'(pal_index), cur.pal);
    chk("frame_idx_loop", int'(frame_idx), frame_of(pulses, 1'b1));
    chk("frame_idx_hold", int'(frame_idx_h), frame_of(pulses, 1'b0));
    chk("anim_done_loop", int'(anim_done), 0);
    chk("anim_done_hold", int'(anim_done_h), int'(pulses >= 24));
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic set_pix(input int sx, input int sy, input int dx, input int dy);
    SpriteX = 10'(sx);
    SpriteY = 10'(sy);
    DrawX   = 10'(dx);
    DrawY   = 10'(dy);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 3'($urandom_range(0, 7));
    rom_mem[0]    = 3'd5;
    rom_mem[10]   = 3'd6;
    rom_mem[29]   = 3'd0;
    rom_mem[465]  = 3'd7;
    rom_mem[899]  = 3'd3;
    rom_mem[1800] = 3'd4;

    vt[0]  = '{100, 100, 100, 100, 0, 1, 1,   0, 1, 5};
    vt[1]  = '{114, 114, 100, 100, 0, 1, 1, 899, 1, 3};
    vt[2]  = '{115, 114, 100, 100, 0, 1, 1, 899, 0, 3};
    vt[3]  = '{ 85,  85, 100, 100, 1, 1, 1,  29, 0, 0};
    vt[4]  = '{114,  85, 100, 100, 1, 1, 1,   0, 1, 5};
    vt[5]  = '{  0,  85,   5, 100, 0, 1, 1,  10, 1, 6};
    vt[6]  = '{635,  85,   5, 100, 0, 1, 1,  10, 0, 6};
    vt[7]  = '{ 85,  85, 100, 100, 0, 0, 1,   0, 0, 5};
    vt[8]  = '{ 85,  85, 100, 100, 0, 1, 0,   0, 0, 5};
    vt[9]  = '{639, 479, 639, 479, 0, 1, 1, 465, 1, 7};
    vt[10] = '{  0,   0,   0,   0, 0, 1, 1, 465, 1, 7};
    vt[11] = '{1020,  5,   0,   0, 0, 1, 1, 465, 0, 7};
    vt[0].dx = 85;
    vt[0].dy = 85;

    // Reset state.
    do_reset();
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_frame_idx", int'(frame_idx), 0);
    chk("rst_anim_done", int'(anim_done_h), 0);

    // Directed vector table: inputs held three cycles, address after one.
    for (int i = 0; i < 12; i++) begin
      set_pix(vt[i].sx, vt[i].sy, vt[i].dx, vt[i].dy);
      mirror = vt[i].mir;
      blank  = vt[i].blk;
      enable = vt[i].en;
      tick();
      chk($sformatf("vec%0d_addr", i), int'(rom_addr), vt[i].addr);
      tick();
      if (i == 0) chk("vec0_latency", int'(pix_valid), 0);
      tick();
      chk($sformatf("vec%0d_valid", i), int'(pix_valid), int'(vt[i].valid));
      chk($sformatf("vec%0d_pal", i), int'(pal_index), vt[i].pal);
    end

    // Left clip: the far right of the screen must never see the sprite.
    set_pix(5, 100, 630, 85);
    mirror = 1'b0;
    for (int x = 630; x < 640; x++) begin
      DrawX = 10'(x);
      tick();
    end
    tick();
    tick();
    chk("clip_right_valid", int'(pix_valid), 0);

    // Animation stepping and LOOP=0 hold.
    do_reset();
    set_pix(100, 100, 0, 0);
    anim_en = 1'b1;
    pulse(7);
    chk("anim7_frame", int'(frame_idx), 0);
    pulse(1);
    chk("anim8_frame", int'(frame_idx), 1);
    set_pix(100, 100, 85, 85);
    tick();
    chk("anim8_origin_addr", int'(rom_addr), 900);
    pulse(16);
    chk("anim24_frame_hold", int'(frame_idx_h), 3);
    chk("anim24_done", int'(anim_done_h), 1);
    pulse(8);
    chk("anim32_frame_loop", int'(frame_idx), 0);
    pulse(8);
    chk("anim40_frame_hold", int'(frame_idx_h), 3);
    chk("anim40_done", int'(anim_done_h), 1);
    chk("anim40_frame_loop", int'(frame_idx), 1);
    anim_en = 1'b0;
    pulse(8);
    chk("anim_en_off_frame", int'(frame_idx), 1);

    // Mid-frame reset with a hitting pixel in flight, frame_start coincident.
    do_reset();
    anim_en = 1'b1;
    blank = 1'b1;
    enable = 1'b1;
    set_pix(100, 100, 0, 0);
    pulse(21);
    chk("mid_frame_before", int'(frame_idx), 2);
    set_pix(100, 100, 85, 85);
    tick();
    tick();
    chk("mid_addr_before", int'(rom_addr), 1800);
    Reset = 1'b1;
    frame_start = 1'b1;
    tick();
    Reset = 1'b0;
    frame_start = 1'b0;
    chk("mid_rst_frame", int'(frame_idx), 0);
    chk("mid_rst_valid", int'(pix_valid), 0);
    chk("mid_rst_addr", int'(rom_addr), 0);
    set_pix(100, 100, 0, 0);
    pulse(7);
    chk("mid_div_cleared", int'(frame_idx), 0);
    pulse(1);
    chk("mid_div_step", int'(frame_idx), 1);

    // Randomized raster traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int t;
      Reset       = ($urandom_range(0, 99) == 0);
      frame_start = ($urandom_range(0, 3) == 0);
      anim_en     = ($urandom_range(0, 3) != 0);
      blank       = ($urandom_range(0, 7) != 0);
      enable      = ($urandom_range(0, 7) != 0);
      mirror      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        SpriteX = 10'($urandom_range(0, 639));
        SpriteY = 10'($urandom_range(0, 479));
      end
      if ($urandom_range(0, 3) == 0) begin
        DrawX = 10'($urandom_range(0, 1023));
        DrawY = 10'($urandom_range(0, 1023));
      end else begin
        t = int'(SpriteX) + int'($urandom_range(0, 40)) - 20;
        DrawX = 10'((t < 0) ? 0 : t);
        t = int'(SpriteY) + int'($urandom_range(0, 40)) - 20;
        DrawY = 10'((t < 0) ? 0 : t);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
